// File: rtl/bin_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_bcd_seq -- sequential binary-to-BCD converter (shift-and-add-3).
//
// Takes a W-bit operand on a start/done handshake and produces DIGITS packed
// BCD digits, one shift per clock. A conversion accepted at edge 0 shifts on
// edges 1..W, publishes bcd/neg at edge W+1, and raises done for the
// following cycle. bcd/neg hold between conversions and never show partial
// results.
//
// Optional feature: define BIN_BCD_SIGNED_EN to treat bin_in as two's
// complement (magnitude is converted, sign reported on neg). When undefined,
// bin_in is unsigned and neg stays 0.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-low reset
//   start  in   conversion request, sampled only when idle
//   bin_in in   W-bit operand, captured on the accepted start cycle
//   busy   out  high from accept through the done cycle
//   done   out  one-cycle pulse when bcd/neg have just been updated
//   bcd    out  packed BCD result, digit 0 (units) in bits [3:0]
//   neg    out  sign of the result
// -----------------------------------------------------------------------------
module bin_bcd_seq #(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [W-1:0]    operand_q, operand_d;
    logic            sign_q,    sign_d;
    logic [BW-1:0]   bcd_q,     bcd_d;
    logic            neg_q,     neg_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    logic [W-1:0]    in_mag;
    logic            in_neg;
    logic [BW-1:0]   corr;
    logic            unused_top_bit;

`ifdef BIN_BCD_SIGNED_EN
    // -2^(W-1) negates to itself, which read as unsigned is the right magnitude.
    assign in_neg = bin_in[W-1];
    assign in_mag = in_neg ? -bin_in : bin_in;
`else
    assign in_neg = 1'b0;
    assign in_mag = bin_in;
`endif

    // Add-3 correction on every digit in parallel, ahead of the shift.
    always_comb begin
        corr = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit shifted out of the top digit is always zero because
    // 10^DIGITS exceeds the largest W-bit value.
    assign unused_top_bit = corr[BW-1];

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        operand_d = operand_q;
        sign_d    = sign_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // While done is still high we are in the done cycle: no accept.
                if (start && !done_q) begin
                    operand_d = in_mag;
                    sign_d    = in_neg;
                    scratch_d = '0;
                    cnt_d     = CW'(W);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy_d    = 1'b1;
                scratch_d = {corr[BW-2:0], operand_q[W-1]};
                operand_d = {operand_q[W-2:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // busy stays high through the done cycle so done implies busy.
                busy_d  = 1'b1;
                done_d  = 1'b1;
                bcd_d   = scratch_q;
                neg_d   = sign_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scratch_q <= '0;
            operand_q <= '0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            operand_q <= operand_d;
            sign_q    <= sign_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign neg  = neg_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_bcd_seq -- self-checking bench for bin_bcd_seq (W=16, DIGITS=5).
// Directed vector table, reset/back-to-back/hold sequences and random operands
// compared against a decimal-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_bin_bcd_seq;

    localparam int W      = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = W + 1;

    logic                clk;
    logic                rst;
    logic                start;
    logic [W-1:0]        bin_in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                neg;

    int n_checks;
    int n_errors;

    bin_bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .neg    (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]        bin;
        logic [4*DIGITS-1:0] exp_bcd;
        logic                exp_neg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division of the magnitude.
    task automatic model(input logic [W-1:0] b, output logic [4*DIGITS-1:0] exp_bcd,
                         output logic exp_neg);
        int unsigned mag;
`ifdef BIN_BCD_SIGNED_EN
        if (b[W-1]) begin
            mag     = (1 << W) - int'(b);
            exp_neg = 1'b1;
        end else begin
            mag     = int'(b);
            exp_neg = 1'b0;
        end
`else
        mag     = int'(b);
        exp_neg = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            exp_bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
    endtask

    // Accept one conversion from idle, then verify latency, busy and result.
    task automatic run_conv(input logic [W-1:0] b, input logic [4*DIGITS-1:0] exp_bcd,
                            input logic exp_neg, input string name);
        int  n;
        bit  busy_ok;
        @(negedge clk);
        start  = 1'b1;
        bin_in = b;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bin_in = W'($urandom);
        n       = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(LAT));
        check({name, " busy during conversion"}, 32'(busy_ok), 32'd1);
        check({name, " busy with done"}, 32'(busy), 32'd1);
        check({name, " bcd"}, 32'(bcd), 32'(exp_bcd));
        check({name, " neg"}, 32'(neg), 32'(exp_neg));
        @(negedge clk);
        check({name, " done one cycle"}, 32'(done), 32'd0);
        check({name, " busy cleared"}, 32'(busy), 32'd0);
    endtask

    vec_t                vecs[7];
    logic [4*DIGITS-1:0] m_bcd;
    logic                m_neg;
    logic [4*DIGITS-1:0] held_bcd;
    logic                held_neg;
    int                  n;
    bit                  seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        start    = 1'b0;
        bin_in   = '0;

        vecs[0] = '{16'd1234,  20'h01234, 1'b0};
        vecs[1] = '{16'd0,     20'h00000, 1'b0};
        vecs[2] = '{16'd9,     20'h00009, 1'b0};
        vecs[3] = '{16'h7FFF,  20'h32767, 1'b0};
`ifdef BIN_BCD_SIGNED_EN
        vecs[4] = '{16'hFFFF,  20'h00001, 1'b1};
        vecs[5] = '{16'h8000,  20'h32768, 1'b1};
        vecs[6] = '{16'hFC18,  20'h01000, 1'b1};
`else
        vecs[4] = '{16'hFFFF,  20'h65535, 1'b0};
        vecs[5] = '{16'h8000,  20'h32768, 1'b0};
        vecs[6] = '{16'd10000, 20'h10000, 1'b0};
`endif

        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset bcd",  32'(bcd),  32'd0);
        check("reset neg",  32'(neg),  32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_conv(vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_neg, $sformatf("vec%0d", i));
        end

        // Reset in the middle of SHIFT aborts without a done pulse.
        run_conv(16'd42, 20'h00042, 1'b0, "pre-reset");
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd1234;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid-shift busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort bcd",  32'(bcd),  32'd0);
        start = 1'b1;
        @(negedge clk);
        check("abort busy 2", 32'(busy), 32'd0);
        check("abort done",   32'(done), 32'd0);
        rst   = 1'b1;
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("no done after abort", 32'(seen), 32'd0);
        check("bcd stays cleared", 32'(bcd), 32'd0);
        run_conv(16'd1234, 20'h01234, 1'b0, "after reset");

        // Back-to-back with start held high: no queuing, one idle gap.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd99;
        @(posedge clk);
        @(negedge clk);
        bin_in = 16'd100;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b first latency", 32'(n), 32'(LAT));
        check("b2b first bcd", 32'(bcd), 32'h00099);
        @(negedge clk);
        check("b2b idle gap busy", 32'(busy), 32'd0);
        check("b2b idle gap done", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b second accepted", 32'(busy), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b second latency", 32'(n), 32'(LAT));
        check("b2b second bcd", 32'(bcd), 32'h00100);
        @(negedge clk);

        // Hold: outputs stay put while idle with a wandering bin_in.
        run_conv(16'd42, 20'h00042, 1'b0, "hold setup");
        held_bcd = bcd;
        held_neg = neg;
        for (int i = 0; i < 10; i++) begin
            bin_in = W'($urandom);
            @(negedge clk);
            check("hold bcd",  32'(bcd),  32'(held_bcd));
            check("hold neg",  32'(neg),  32'(held_neg));
            check("hold done", 32'(done), 32'd0);
        end

        // Random operands against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] b;
            b = W'($urandom_range(0, (1 << W) - 1));
            model(b, m_bcd, m_neg);
            run_conv(b, m_bcd, m_neg, $sformatf("rand%0d(%0h)", i, b));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
